// File: rtl/button_debounce_pkg.sv
// ----------------------------------------------------------------------------
// button_debounce_pkg
//   Shared definitions for the button debounce front end.
//   - state_t      : 2-bit FSM state encoding (IDLE_LOW/WAIT_HIGH/IDLE_HIGH/
//                    WAIT_LOW = 00/01/10/11). The MSB of the IDLE states equals
//                    the debounced level they represent.
//   - GLITCH_W     : width of the optional rejected-transition counter.
//   - glitch_inc() : saturating increment used by that counter.
// ----------------------------------------------------------------------------
package button_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_IDLE_HIGH = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } state_t;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    // Saturating increment: the counter sticks at all-ones rather than
    // wrapping, so a large reading can never be mistaken for a small one.
    function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] cnt);
        if (cnt == GLITCH_MAX) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/button_debounce_sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//   Parameterised flop chain that brings an asynchronous single-bit input
//   into the clk domain. All stages reset to 0. Reusable for any async pin.
//
// Parameters
//   STAGES  number of flops in the chain (>= 2 for metastability settling)
// Ports
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous, active-high; clears every stage to 0
//   d      in  1  asynchronous input
//   q      out 1  synchronised output (last stage)
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_stage;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic w_din;
            if (gi == 0) begin : g_first
                assign w_din = d;
            end else begin : g_rest
                assign w_din = r_stage[gi-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stage[gi] <= 1'b0;
                end else begin
                    r_stage[gi] <= w_din;
                end
            end
        end
    endgenerate

    assign q = r_stage[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Conditions a raw, bouncing button/switch pin. The pin is synchronised
//   into clk, then a level change is only accepted once the synchronised
//   value has held for STABLE_CYCLES consecutive samples after leaving an
//   IDLE state. Any opposite sample during qualification aborts and the
//   counter restarts from 0 on the next attempt (no partial credit).
//
//   Latency: if edge 0 is the first clk edge sampling a stable btn_in,
//   btn_level changes on edge SYNC_STAGES + STABLE_CYCLES.
//
// Parameters
//   SYNC_STAGES    synchroniser depth, >= 2
//   STABLE_CYCLES  stable samples needed to accept a change, >= 2
//   CNT_W          stability counter width, 2**CNT_W > STABLE_CYCLES-1
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous assert, active-high (release must be
//                         synchronous to clk upstream)
//   btn_in        in   1  raw pin, asynchronous, may bounce
//   btn_level     out  1  debounced level, registered
//   btn_changed   out  1  registered 1-cycle pulse on every btn_level change
//   glitch_count  out  8  saturating count of aborted qualifications;
//                         only present when DEBOUNCE_GLITCH_CNT_EN is defined
//
// Build option
//   DEBOUNCE_GLITCH_CNT_EN : adds the glitch_count port and counter.
// ----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_changed
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_count
`endif
);

    // The terminal compare fires at STABLE_CYCLES-1, so the counter never
    // needs to represent STABLE_CYCLES itself and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

    logic              w_s;        // synchronised pin
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level;
    logic              r_changed;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (w_s)
    );

    // State, counter and outputs all update on the same edge, so btn_level
    // and btn_changed are true registers with no path from btn_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            r_glitch  <= '0;
`endif
        end else begin
            r_changed <= 1'b0;

            case (r_state)
                ST_IDLE_LOW: begin
                    r_cnt <= '0;
                    if (w_s) begin
                        r_state <= ST_WAIT_HIGH;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (!w_s) begin
                        // Opposite sample: discard progress, count a glitch.
                        r_state <= ST_IDLE_LOW;
                        r_cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        r_glitch <= glitch_inc(r_glitch);
`endif
                    end else if (r_cnt == CNT_TERM) begin
                        r_state   <= ST_IDLE_HIGH;
                        r_cnt     <= '0;
                        r_level   <= 1'b1;
                        r_changed <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_IDLE_HIGH: begin
                    r_cnt <= '0;
                    if (!w_s) begin
                        r_state <= ST_WAIT_LOW;
                    end
                end

                ST_WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= ST_IDLE_HIGH;
                        r_cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        r_glitch <= glitch_inc(r_glitch);
`endif
                    end else if (r_cnt == CNT_TERM) begin
                        r_state   <= ST_IDLE_LOW;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_changed <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE_LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_changed = r_changed;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    assign glitch_count = r_glitch;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
//   Self-checking bench for button_debounce with SYNC_STAGES=2,
//   STABLE_CYCLES=4. A run-length reference model (samples delayed through a
//   queue, level flips after STABLE_CYCLES+1 consecutive differing samples)
//   predicts btn_level/btn_changed/glitch_count every cycle; directed
//   scenarios additionally check absolute edge latencies and pulse counts.
//   Define DEBOUNCE_GLITCH_CNT_EN to also check glitch_count.
// ----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LAT    = SYNC + STABLE;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       btn_changed;
    logic [7:0] glitch_count;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic       pipe_q[$];
    logic       m_level;
    logic       m_changed;
    int         m_run;
    int         m_glitch;

    button_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .btn_changed  (btn_changed)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

`ifndef DEBOUNCE_GLITCH_CNT_EN
    assign glitch_count = 8'h00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        for (int i = 0; i < SYNC; i++) pipe_q.push_back(1'b0);
        m_level   = 1'b0;
        m_changed = 1'b0;
        m_run     = 0;
        m_glitch  = 0;
    endtask

    // One clk edge of the behavioural model: the sample seen by the
    // qualifier is btn_in from SYNC edges ago.
    task automatic model_edge(input logic b);
        logic s;
        pipe_q.push_back(b);
        s = pipe_q.pop_front();
        m_changed = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == STABLE + 1) begin
                m_level   = s;
                m_changed = 1'b1;
                m_run     = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
        end
    endtask

    // Called from negedge: drive, clock, compare 1 time unit after the edge,
    // return at the following negedge.
    task automatic step(input logic b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check("level", int'(btn_level), int'(m_level));
        check("changed", int'(btn_changed), int'(m_changed));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch", int'(glitch_count), m_glitch);
`endif
        @(negedge clk);
    endtask

    task automatic pulse_reset(input logic b, input int cycles);
        btn_in = b;
        reset  = 1'b1;
        #1;
        model_reset();
        check("rst_level", int'(btn_level), 0);
        check("rst_changed", int'(btn_changed), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("rst_glitch", int'(glitch_count), 0);
`endif
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold btn_in at b for a bounded window; check the edge index of the
    // level change and that exactly one btn_changed pulse occurred.
    task automatic measure(input logic b, input int exp_edge, input string tag);
        int first = -1;
        int pulses = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            step(b);
            if (btn_changed) pulses++;
            if (first < 0 && btn_level == b) first = i;
        end
        check({tag, "_edge"}, first, exp_edge);
        check({tag, "_pulses"}, pulses, 1);
    endtask

    initial begin
        int g0;
        int pulses;
        int len;
        logic b;

        reset  = 1'b0;
        btn_in = 1'b0;
        @(negedge clk);

        // 1. Reset held with btn high, then requalification after release.
        pulse_reset(1'b1, 3);
        measure(1'b1, LAT, "t1_rise");
        $display("t1 reset-held-high: level=%0d", btn_level);

        // 2. Clean release then clean press.
        measure(1'b0, LAT, "t2_fall");
        measure(1'b1, LAT, "t2_rise");
        measure(1'b0, LAT, "t2_fall2");
        $display("t2 clean press/release: level=%0d", btn_level);

        // 3. Bounce 5x (high 3 / low 1): rejected, five glitches.
        g0 = int'(glitch_count);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(k < 3);
                if (btn_changed) pulses++;
            end
        end
        repeat (LAT) begin
            step(1'b0);
            if (btn_changed) pulses++;
        end
        check("t3_level", int'(btn_level), 0);
        check("t3_pulses", pulses, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t3_glitch_delta", int'(glitch_count) - g0, 5);
`endif
        $display("t3 bounce rejected: glitch_count=%0d", glitch_count);

        // 4. Bounce (high 2 / low 1) x3 then hold: no residue from bounces.
        for (int r = 0; r < 3; r++) begin
            step(1'b1);
            step(1'b1);
            step(1'b0);
        end
        measure(1'b1, LAT, "t4_rise");
        measure(1'b0, LAT, "t4_fall");
        $display("t4 bounce then hold: level=%0d", btn_level);

        // 5. Reset mid-qualification (WAIT_HIGH, cnt=2) with btn still high.
        for (int i = 0; i < SYNC + 3; i++) step(1'b1);
        check("t5_pre_level", int'(btn_level), 0);
        pulse_reset(1'b1, 2);
        measure(1'b1, LAT, "t5_rise");
        measure(1'b0, LAT, "t5_fall");
        $display("t5 reset mid-wait: level=%0d", btn_level);

        // 6. 300 single-cycle glitches: counter saturates.
        for (int r = 0; r < 300; r++) begin
            step(1'b1);
            step(1'b0);
        end
        repeat (LAT) step(1'b0);
        check("t6_level", int'(btn_level), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t6_glitch_sat", int'(glitch_count), 255);
`endif
        $display("t6 glitch storm: glitch_count=%0d", glitch_count);

        // 7. Random run-length stimulus against the model.
        for (int r = 0; r < 600; r++) begin
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            repeat (len) step(b);
        end
        $display("t7 random runs: level=%0d", btn_level);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
